// File: rtl/space_wire_tx_packet_framer.sv
// -----------------------------------------------------------------------------
// space_wire_tx_packet_framer
//
// Transmit-side packet framer between the host TX FIFO and the SpaceWire link
// transmit port. Each character is read from the FIFO, held, and presented to
// the link until it is accepted. The framer also enforces a maximum packet
// length and discards the tail of a packet when the link drops mid-packet.
//
// When the length limit is reached it inserts an EEP and then flushes the rest
// of that packet. When the link drops mid-packet it flushes as well.
//
// Parameters:
//   C_MAX_PKT_LEN          max data bytes per packet, 0 disables the check
//
// Ports:
//   i_clk                  system clock
//   i_reset                asynchronous active-low reset
//   i_link_running         link is in Run state
//   i_fifo_empty           host TX FIFO empty
//   o_fifo_rd_en           FIFO read strobe, data valid on the following cycle
//   i_fifo_rd_data         FIFO character, bit 8 = control (0x00 EOP, 0x01 EEP)
//   o_tx_data_en           character valid toward the link
//   o_tx_data              character byte
//   o_tx_data_control_flag 1 = EOP/EEP marker
//   i_tx_ready             link accepts a character this cycle
//   o_busy                 framer not idle
//   o_flushing             framer discarding the rest of a packet
//   o_pkt_count            packets completed on the link, wraps
//   o_trunc_count          packets truncated by length or link drop, saturates
// -----------------------------------------------------------------------------
module space_wire_tx_packet_framer #(
  parameter logic [15:0] C_MAX_PKT_LEN = 16'd1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_link_running,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd_en,
  input  logic [8:0]  i_fifo_rd_data,
  output logic        o_tx_data_en,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_data_control_flag,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_flushing,
  output logic [15:0] o_pkt_count,
  output logic [7:0]  o_trunc_count
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StSend,
    StInsertEep,
    StFlush
  } state_e;

  state_e      state_q, state_d;
  logic        in_pkt_q, in_pkt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [8:0]  hold_q, hold_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [7:0]  trunc_count_q, trunc_count_d;
  // A FLUSH read is in flight; its data is on i_fifo_rd_data this cycle.
  logic        flush_rd_q, flush_rd_d;

  logic        fifo_rd_en;
  logic        tx_data_en;
  logic [7:0]  tx_data;
  logic        tx_flag;
  logic [15:0] byte_cnt_inc;
  logic [7:0]  trunc_count_inc;

  // byte_cnt only reaches 0xFFFF when the limit is disabled; hold it there.
  assign byte_cnt_inc    = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign trunc_count_inc = (trunc_count_q == 8'hFF) ? trunc_count_q : trunc_count_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    in_pkt_d      = in_pkt_q;
    byte_cnt_d    = byte_cnt_q;
    hold_d        = hold_q;
    pkt_count_d   = pkt_count_q;
    trunc_count_d = trunc_count_q;
    flush_rd_d    = 1'b0;
    fifo_rd_en    = 1'b0;
    tx_data_en    = 1'b0;
    tx_data       = 8'h00;
    tx_flag       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_pkt_q && !i_link_running) begin
          state_d       = StFlush;
          trunc_count_d = trunc_count_inc;
        end else if (i_link_running && !i_fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = StRead;
        end
      end

      StRead: begin
        hold_d  = i_fifo_rd_data;
        state_d = StSend;
      end

      StSend: begin
        // Gating with the link status keeps a dropped character from being
        // taken by the link on the drop cycle.
        tx_data_en = i_link_running;
        tx_data    = hold_q[7:0];
        tx_flag    = hold_q[8];
        if (!i_link_running) begin
          if (hold_q[8]) begin
            in_pkt_d   = 1'b0;
            byte_cnt_d = 16'd0;
            state_d    = StIdle;
          end else begin
            trunc_count_d = trunc_count_inc;
            state_d       = StFlush;
          end
        end else if (i_tx_ready) begin
          if (hold_q[8]) begin
            in_pkt_d    = 1'b0;
            byte_cnt_d  = 16'd0;
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = StIdle;
          end else begin
            in_pkt_d   = 1'b1;
            byte_cnt_d = byte_cnt_inc;
            if ((C_MAX_PKT_LEN != 16'd0) && (byte_cnt_inc == C_MAX_PKT_LEN)) begin
              state_d = StInsertEep;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end

      StInsertEep: begin
        tx_data_en = i_link_running;
        tx_data    = 8'h01;
        tx_flag    = 1'b1;
        if (!i_link_running) begin
          state_d = StFlush;
        end else if (i_tx_ready) begin
          pkt_count_d   = pkt_count_q + 16'd1;
          trunc_count_d = trunc_count_inc;
          state_d       = StFlush;
        end
      end

      StFlush: begin
        if (flush_rd_q) begin
          if (i_fifo_rd_data[8]) begin
            in_pkt_d   = 1'b0;
            byte_cnt_d = 16'd0;
            state_d    = StIdle;
          end
        end else if (!i_fifo_empty) begin
          fifo_rd_en = 1'b1;
          flush_rd_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= StIdle;
      in_pkt_q      <= 1'b0;
      byte_cnt_q    <= 16'd0;
      hold_q        <= 9'd0;
      pkt_count_q   <= 16'd0;
      trunc_count_q <= 8'd0;
      flush_rd_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_pkt_q      <= in_pkt_d;
      byte_cnt_q    <= byte_cnt_d;
      hold_q        <= hold_d;
      pkt_count_q   <= pkt_count_d;
      trunc_count_q <= trunc_count_d;
      flush_rd_q    <= flush_rd_d;
    end
  end

  // The IDLE read decision is combinational on FIFO/link inputs, so it is
  // masked while reset is held to keep the FIFO from being popped.
  assign o_fifo_rd_en           = fifo_rd_en & i_reset;
  assign o_tx_data_en           = tx_data_en;
  assign o_tx_data              = tx_data;
  assign o_tx_data_control_flag = tx_flag;
  assign o_busy                 = (state_q != StIdle);
  assign o_flushing             = (state_q == StFlush);
  assign o_pkt_count            = pkt_count_q;
  assign o_trunc_count          = trunc_count_q;

endmodule

// File: tb/tb_space_wire_tx_packet_framer.sv
module tb_space_wire_tx_packet_framer;

  localparam logic [15:0] MaxLen = 16'd4;
  localparam logic [8:0]  EOP    = 9'h100;
  localparam logic [8:0]  EEP    = 9'h101;
  localparam logic [8:0]  Z      = 9'h000;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_link_running = 1'b0;
  logic        fifo_empty;
  logic        o_fifo_rd_en;
  logic [8:0]  fifo_rd_data = '0;
  logic        o_tx_data_en;
  logic [7:0]  o_tx_data;
  logic        o_tx_data_control_flag;
  logic        i_tx_ready = 1'b0;
  logic        o_busy;
  logic        o_flushing;
  logic [15:0] o_pkt_count;
  logic [7:0]  o_trunc_count;

  always #5 i_clk = ~i_clk;

  space_wire_tx_packet_framer #(
    .C_MAX_PKT_LEN(MaxLen)
  ) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_link_running        (i_link_running),
    .i_fifo_empty          (fifo_empty),
    .o_fifo_rd_en          (o_fifo_rd_en),
    .i_fifo_rd_data        (fifo_rd_data),
    .o_tx_data_en          (o_tx_data_en),
    .o_tx_data             (o_tx_data),
    .o_tx_data_control_flag(o_tx_data_control_flag),
    .i_tx_ready            (i_tx_ready),
    .o_busy                (o_busy),
    .o_flushing            (o_flushing),
    .o_pkt_count           (o_pkt_count),
    .o_trunc_count         (o_trunc_count)
  );

  // Host FIFO model: read data appears the cycle after the strobe.
  logic [8:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge i_clk) begin
    if (o_fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  typedef struct packed {
    logic [3:0]       n_in;
    logic [0:7][8:0]  in_c;
    logic [3:0]       n_out;
    logic [0:7][8:0]  out_c;
    logic [15:0]      pkt;
    logic [7:0]       trunc;
    logic             rnd;
  } vec_t;

  vec_t       vecs [6];
  logic [8:0] sb [$];
  int         xfer_log [$];
  int         rd_log [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  task automatic push(input logic [8:0] c);
    mem[wr_ptr] = c;
    wr_ptr++;
  endtask

  // Sample at the falling edge, then hand back control just after the next
  // rising edge so the caller drives inputs for the new cycle.
  task automatic tick();
    logic [8:0] e;
    @(negedge i_clk);
    cyc++;
    if (o_tx_data_en && i_tx_ready) begin
      xfer_log.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got 0x%0h expected nothing", {o_tx_data_control_flag, o_tx_data});
      end else begin
        e = sb.pop_front();
        chk("tx_char", 32'({o_tx_data_control_flag, o_tx_data}), 32'(e));
      end
    end
    if (o_tx_data_en && o_flushing) chk("no_tx_in_flush", 32'(o_tx_data_en), 32'd0);
    if (o_fifo_rd_en) rd_log.push_back(cyc);
    @(posedge i_clk);
    #1;
    if (rnd_ready) i_tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(fifo_empty && !o_busy && sb.size() == 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) timeout(name);
  endtask

  task automatic wait_char(input logic [8:0] c, input string name);
    int n = 0;
    while (!(o_tx_data_en && {o_tx_data_control_flag, o_tx_data} == c) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeout(name);
  endtask

  initial begin
    vecs[0].n_in = 4'd4; vecs[0].in_c = {9'h011, 9'h022, 9'h033, EOP, Z, Z, Z, Z};
    vecs[0].n_out = 4'd4; vecs[0].out_c = vecs[0].in_c;
    vecs[0].pkt = 16'd1; vecs[0].trunc = 8'd0; vecs[0].rnd = 1'b0;
    vecs[1].n_in = 4'd2; vecs[1].in_c = {9'h055, EEP, Z, Z, Z, Z, Z, Z};
    vecs[1].n_out = 4'd2; vecs[1].out_c = vecs[1].in_c;
    vecs[1].pkt = 16'd2; vecs[1].trunc = 8'd0; vecs[1].rnd = 1'b1;
    vecs[2].n_in = 4'd7;
    vecs[2].in_c = {9'h0a1, 9'h0a2, 9'h0a3, 9'h0a4, 9'h0a5, 9'h0a6, EOP, Z};
    vecs[2].n_out = 4'd5; vecs[2].out_c = {9'h0a1, 9'h0a2, 9'h0a3, 9'h0a4, EEP, Z, Z, Z};
    vecs[2].pkt = 16'd3; vecs[2].trunc = 8'd1; vecs[2].rnd = 1'b1;
    vecs[3].n_in = 4'd3; vecs[3].in_c = {9'h001, 9'h077, EOP, Z, Z, Z, Z, Z};
    vecs[3].n_out = 4'd3; vecs[3].out_c = vecs[3].in_c;
    vecs[3].pkt = 16'd4; vecs[3].trunc = 8'd1; vecs[3].rnd = 1'b0;
    vecs[4].n_in = 4'd5; vecs[4].in_c = {9'h0b1, 9'h0b2, 9'h0b3, 9'h0b4, EOP, Z, Z, Z};
    vecs[4].n_out = 4'd5; vecs[4].out_c = {9'h0b1, 9'h0b2, 9'h0b3, 9'h0b4, EEP, Z, Z, Z};
    vecs[4].pkt = 16'd5; vecs[4].trunc = 8'd2; vecs[4].rnd = 1'b1;
    vecs[5].n_in = 4'd1; vecs[5].in_c = {EOP, Z, Z, Z, Z, Z, Z, Z};
    vecs[5].n_out = 4'd1; vecs[5].out_c = vecs[5].in_c;
    vecs[5].pkt = 16'd6; vecs[5].trunc = 8'd2; vecs[5].rnd = 1'b0;

    // Reset state, with link up and FIFO non-empty so the read mask matters.
    i_link_running = 1'b1;
    push(9'h0ee);
    #1;
    chk("reset_rd_en", 32'(o_fifo_rd_en), 32'd0);
    tick();
    tick();
    chk("reset_tx_en", 32'(o_tx_data_en), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_pkt", 32'(o_pkt_count), 32'd0);
    chk("reset_trunc", 32'(o_trunc_count), 32'd0);
    // Drain the pre-reset character as its own EOP-less data byte followed by EOP.
    push(EOP);
    sb.push_back(9'h0ee);
    sb.push_back(EOP);
    i_reset = 1'b1;
    i_tx_ready = 1'b1;
    wait_idle("reset_drain");
    i_reset = 1'b0;
    #1;
    i_reset = 1'b1;
    chk("pre_table_pkt", 32'(o_pkt_count), 32'd0);

    for (int v = 0; v < 6; v++) begin
      rnd_ready = vecs[v].rnd;
      i_tx_ready = 1'b1;
      xfer_log.delete();
      rd_log.delete();
      for (int j = 0; j < int'(vecs[v].n_in); j++) push(vecs[v].in_c[j]);
      for (int j = 0; j < int'(vecs[v].n_out); j++) sb.push_back(vecs[v].out_c[j]);
      wait_idle("vec_done");
      chk("vec_pkt_count", 32'(o_pkt_count), 32'(vecs[v].pkt));
      chk("vec_trunc_count", 32'(o_trunc_count), 32'(vecs[v].trunc));
      if (v == 0) begin
        chk("v0_xfers", 32'(xfer_log.size()), 32'd4);
        for (int i = 0; i < xfer_log.size() && i < rd_log.size(); i++) begin
          chk("v0_rd_to_tx_latency", 32'(xfer_log[i] - rd_log[i]), 32'd2);
          if (i > 0) chk("v0_cadence", 32'(xfer_log[i] - xfer_log[i-1]), 32'd3);
        end
      end
      rnd_ready = 1'b0;
    end

    // Backpressure: 0x22 held for 6 cycles with ready low for 5.
    i_tx_ready = 1'b1;
    push(9'h011); push(9'h022); push(9'h033); push(EOP);
    sb.push_back(9'h011); sb.push_back(9'h022); sb.push_back(9'h033); sb.push_back(EOP);
    begin
      int n = 0;
      while (sb.size() != 3 && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) timeout("stall_first");
    end
    i_tx_ready = 1'b0;
    wait_char(9'h022, "stall_reach");
    for (int k = 0; k < 6; k++) begin
      chk("stall_en", 32'(o_tx_data_en), 32'd1);
      chk("stall_data", 32'({o_tx_data_control_flag, o_tx_data}), 32'h022);
      chk("stall_no_rd", 32'(o_fifo_rd_en), 32'd0);
      if (k == 5) i_tx_ready = 1'b1;
      tick();
    end
    wait_idle("stall_done");
    chk("stall_pkt", 32'(o_pkt_count), 32'd7);
    chk("stall_trunc", 32'(o_trunc_count), 32'd2);

    // Link drop while byte 2 of 5 is held; ready high to exercise priority.
    i_tx_ready = 1'b0;
    push(9'h0c1); push(9'h0c2); push(9'h0c3); push(9'h0c4); push(9'h0c5); push(EOP);
    sb.push_back(9'h0c1);
    wait_char(9'h0c1, "drop_c1");
    i_tx_ready = 1'b1;
    tick();
    i_tx_ready = 1'b0;
    wait_char(9'h0c2, "drop_c2");
    i_link_running = 1'b0;
    i_tx_ready = 1'b1;
    tick();
    chk("drop_flushing", 32'(o_flushing), 32'd1);
    wait_idle("drop_done");
    chk("drop_trunc", 32'(o_trunc_count), 32'd3);
    chk("drop_pkt", 32'(o_pkt_count), 32'd7);
    chk("drop_busy", 32'(o_busy), 32'd0);
    i_link_running = 1'b1;

    // Asynchronous reset while byte 2 is held; counts and byte_cnt restart.
    i_tx_ready = 1'b0;
    push(9'h0d1); push(9'h0d2); push(EOP);
    sb.push_back(9'h0d1);
    wait_char(9'h0d1, "rst_d1");
    i_tx_ready = 1'b1;
    tick();
    i_tx_ready = 1'b0;
    wait_char(9'h0d2, "rst_d2");
    i_reset = 1'b0;
    #1;
    chk("rst_tx_en", 32'(o_tx_data_en), 32'd0);
    chk("rst_tx_data", 32'({o_tx_data_control_flag, o_tx_data}), 32'd0);
    chk("rst_rd_en", 32'(o_fifo_rd_en), 32'd0);
    chk("rst_busy", 32'({o_busy, o_flushing}), 32'd0);
    chk("rst_pkt", 32'(o_pkt_count), 32'd0);
    chk("rst_trunc", 32'(o_trunc_count), 32'd0);
    tick();
    tick();
    i_reset = 1'b1;
    i_tx_ready = 1'b1;
    sb.push_back(EOP);
    push(9'h0f1); push(9'h0f2); push(9'h0f3); push(9'h0f4); push(EOP);
    sb.push_back(9'h0f1); sb.push_back(9'h0f2); sb.push_back(9'h0f3); sb.push_back(9'h0f4);
    sb.push_back(EEP);
    wait_idle("post_rst_done");
    chk("post_rst_pkt", 32'(o_pkt_count), 32'd2);
    chk("post_rst_trunc", 32'(o_trunc_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/space_wire_tx_packet_framer.md
# space_wire_tx_packet_framer

Transmit-side packet framer sitting directly upstream of the SpaceWire link interface transmit port. Reads 9-bit characters (data byte or EOP/EEP marker) from the host TX FIFO and presents them to the link's `i_tx_data_en` / `i_tx_data` / `i_tx_data_control_flag` / `o_tx_ready` handshake. It also enforces a maximum packet length by truncating with an EEP, and discards the remainder of a packet when the link drops mid-packet.

## Interface
Parameters:
- `C_MAX_PKT_LEN`, 16'd1024, max data bytes per packet; 0 disables the length check.

Ports:
- `i_clk`  in  1  system clock; the block's only clock.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_link_running`  in  1  link in Run state; driven from link status bit 4 (send_n_char).
- `i_fifo_empty`  in  1  host TX FIFO empty.
- `o_fifo_rd_en`  out  1  FIFO read strobe, one cycle; data is valid on the next cycle.
- `i_fifo_rd_data`  in  9  bit 8 = control flag; control chars: 0x00 = EOP, 0x01 = EEP.
- `o_tx_data_en`  out  1  character valid toward the link.
- `o_tx_data`  out  8  character byte.
- `o_tx_data_control_flag`  out  1  1 = EOP/EEP marker.
- `i_tx_ready`  in  1  link accepts a character this cycle.
- `o_busy`  out  1  state is not IDLE.
- `o_flushing`  out  1  state is FLUSH.
- `o_pkt_count`  out  16  packets completed on the link (EOP, EEP, or inserted EEP); wraps.
- `o_trunc_count`  out  8  packets truncated by length limit or link drop; saturates at 255.

## Operation
- States: IDLE, READ, SEND, INSERT_EEP, FLUSH. Internal `in_pkt` flag, 16-bit `byte_cnt`, 9-bit hold register.
- IDLE:
  - `in_pkt`=1 and `i_link_running`=0 → FLUSH, `o_trunc_count`++.
  - Otherwise, `i_link_running`=1 and `i_fifo_empty`=0 → pulse `o_fifo_rd_en` → READ.
- READ: latch `i_fifo_rd_data` into the hold register → SEND.
- SEND:
  - `o_tx_data_en`=1 with the hold register contents, held stable.
  - A transfer occurs on a cycle with `o_tx_data_en` & `i_tx_ready`.
  - Data transfer: `byte_cnt`++, `in_pkt`=1.
    - If `C_MAX_PKT_LEN`≠0 and the new `byte_cnt` == `C_MAX_PKT_LEN` → INSERT_EEP.
    - Otherwise → IDLE.
  - Control transfer: `byte_cnt`=0, `in_pkt`=0, `o_pkt_count`++ → IDLE.
- Link drop in SEND (`i_link_running`=0 before transfer): the held character is dropped.
  - Held data → FLUSH, `o_trunc_count`++.
  - Held control → `in_pkt`=0, `byte_cnt`=0, IDLE (no count).
  - The drop check has priority over `i_tx_ready` in the same cycle.
- INSERT_EEP:
  - Drives 0x01 with control flag 1.
  - On transfer: `o_pkt_count`++, `o_trunc_count`++ → FLUSH.
  - On link drop: no counts → FLUSH.
- FLUSH:
  - Reads the FIFO whenever it is non-empty and discards the characters, independent of `i_link_running`.
  - On the cycle a read control char is returned: `in_pkt`=0, `byte_cnt`=0 → IDLE.
  - Never issues a second read before the previous read's data has returned.
- `byte_cnt` is compared as 16-bit unsigned and never wraps, because the limit forces a reset first.
- With `C_MAX_PKT_LEN`=0 it saturates at 0xFFFF.
- Only one FIFO read is outstanding at any time. `o_tx_data_en` is never asserted outside SEND and INSERT_EEP.

## Timing
- Reset: all outputs 0, state IDLE, `in_pkt`=0, `byte_cnt`=0, hold register 0.
- Reset mid-packet discards all state; no EEP is sent.
- Normal path with `i_tx_ready` held high: `o_fifo_rd_en` at cycle N, `o_tx_data_en` from cycle N+2, transfer at N+2, IDLE at N+3.
  - Throughput: one character per 3 cycles.
- Backpressure: `o_tx_data_en` and data stay stable until `i_tx_ready`=1; no additional FIFO reads meanwhile.
- INSERT_EEP is entered the cycle after the limit byte transfers; the EEP is presented on that same cycle.
- `o_pkt_count` / `o_trunc_count` update the cycle after the triggering transfer or transition.
- FLUSH read cadence: at most one `o_fifo_rd_en` every 2 cycles.

## Test plan
- FIFO holds 0x11, 0x22, 0x33, EOP; ready high → `o_tx_data` 0x11, 0x22, 0x33, then 0x00 with flag 1, 3 cycles apart. `o_pkt_count`=1, `o_trunc_count`=0.
- Same packet with `i_tx_ready` low for 5 cycles on byte 0x22 → 0x22 held stable for 6 cycles, no `o_fifo_rd_en` during the stall, output order unchanged.
- `C_MAX_PKT_LEN`=4; packet of 6 data bytes + EOP → 4 bytes, then 0x01 with flag 1. Remaining 2 bytes + EOP are read and not sent. `o_pkt_count`=1, `o_trunc_count`=1; next packet transmits normally.
- `i_link_running` falls while byte 2 of 5 is held in SEND → no transfer, FLUSH consumes through the EOP, `o_trunc_count`=1, `o_pkt_count`=0, `o_busy`=0 afterwards.
- FIFO supplies an EEP (0x01, flag 1) from the host → it is forwarded unchanged and `o_pkt_count` increments.
- Assert `i_reset` low mid-packet in SEND → all outputs 0 immediately (asynchronous). After release, the next FIFO char is sent with `byte_cnt` restarting at 0.
